// File: rtl/ball_motion_ctrl.sv
// ball_motion_ctrl
// Per-frame ball update stage. A frame_tick walks a four-state sequence:
// IDLE -> SAMPLE -> RESOLVE -> MOVE. SAMPLE holds the ball still so the
// downstream edge checker can register it, RESOLVE consumes the edge code
// and brick index (miss > edge hit > live brick > nothing), and MOVE commits
// the new position and raises done. Status flags win/game_over are sticky
// until reset and freeze the sequencer.

module ball_motion_ctrl #(
    parameter int X_INIT = 320,
    parameter int Y_INIT = 400,
    parameter int XSTEP  = 2,
    parameter int YSTEP  = 2,
    parameter int Y_MAX  = 640,
    parameter int LIVES  = 3
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        frame_tick,
    input  logic [1:0]  edge_col,
    input  logic [3:0]  brick_num,
    output logic [9:0]  ball_x,
    output logic [9:0]  ball_y,
    output logic [9:0]  cand_x,
    output logic [9:0]  cand_y,
    output logic [1:0]  dir,
    output logic [11:0] alive,
    output logic        clr_valid,
    output logic [3:0]  clr_num,
    output logic [1:0]  lives,
    output logic        done,
    output logic        win,
    output logic        game_over
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_SAMPLE  = 2'd1;
    localparam logic [1:0] ST_RESOLVE = 2'd2;
    localparam logic [1:0] ST_MOVE    = 2'd3;

    localparam logic [9:0]  X_INIT_C = X_INIT[9:0];
    localparam logic [9:0]  Y_INIT_C = Y_INIT[9:0];
    localparam logic [6:0]  XSTEP_C  = XSTEP[6:0];
    localparam logic [6:0]  YSTEP_C  = YSTEP[6:0];
    localparam logic [10:0] Y_MAX_C  = Y_MAX[10:0];
    localparam logic [1:0]  LIVES_C  = LIVES[1:0];

    // One axis step: clamp at 0 going negative, saturate at 1023 going positive.
    function automatic logic [9:0] step_axis(
        input logic [9:0] pos,
        input logic       neg,
        input logic [6:0] step
    );
        logic [10:0] wide_pos;
        logic [10:0] wide_step;
        logic [10:0] sum;
        logic [10:0] res;
        wide_pos  = {1'b0, pos};
        wide_step = {4'b0000, step};
        sum       = wide_pos + wide_step;
        if (neg) begin
            res = (wide_pos >= wide_step) ? (wide_pos - wide_step) : 11'd0;
        end else begin
            res = (sum > 11'd1023) ? 11'd1023 : sum;
        end
        return res[9:0];
    endfunction

    logic [1:0]  state_r;
    logic [9:0]  ball_x_r;
    logic [9:0]  ball_y_r;
    logic [1:0]  dir_r;
    logic [11:0] alive_r;
    logic        clr_valid_r;
    logic [3:0]  clr_num_r;
    logic [1:0]  lives_r;
    logic        done_r;
    logic        win_r;
    logic        game_over_r;
    logic        reload_r;

    logic [9:0]  cand_x_s;
    logic [9:0]  cand_y_s;
    logic [10:0] y_plus_s;
    logic        miss_s;
    logic        brick_alive_s;
    logic [11:0] brick_mask_s;

    // Candidate position and RESOLVE decode from current ball, dir and inputs.
    always_comb begin
        cand_x_s      = step_axis(ball_x_r, dir_r[0], XSTEP_C);
        cand_y_s      = step_axis(ball_y_r, dir_r[1], YSTEP_C);
        y_plus_s      = {1'b0, ball_y_r} + {4'b0000, YSTEP_C};
        miss_s        = (edge_col == 2'b11) && !dir_r[1] && (y_plus_s >= Y_MAX_C);
        brick_mask_s  = 12'd0;
        brick_alive_s = 1'b0;
        if (brick_num < 4'd12) begin
            brick_mask_s  = 12'd1 << brick_num;
            brick_alive_s = |(alive_r & brick_mask_s);
        end else begin
            brick_mask_s  = 12'd0;
            brick_alive_s = 1'b0;
        end
    end

    // Frame sequencer: a tick only starts an update from IDLE while the game is live.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_r <= ST_IDLE;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (frame_tick && !win_r && !game_over_r) begin
                        state_r <= ST_SAMPLE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_SAMPLE:  state_r <= ST_RESOLVE;
                ST_RESOLVE: state_r <= ST_MOVE;
                ST_MOVE:    state_r <= ST_IDLE;
                default:    state_r <= ST_IDLE;
            endcase
        end
    end

    // Game state: collision resolution in RESOLVE, position commit in MOVE.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            ball_x_r    <= X_INIT_C;
            ball_y_r    <= Y_INIT_C;
            dir_r       <= 2'b11;
            alive_r     <= 12'hFFF;
            clr_valid_r <= 1'b0;
            clr_num_r   <= 4'd0;
            lives_r     <= LIVES_C;
            done_r      <= 1'b0;
            win_r       <= 1'b0;
            game_over_r <= 1'b0;
            reload_r    <= 1'b0;
        end else begin
            clr_valid_r <= 1'b0;
            done_r      <= 1'b0;
            case (state_r)
                ST_RESOLVE: begin
                    reload_r <= 1'b0;
                    if (miss_s) begin
                        // Ball fell past the bottom: lose a life, respawn in MOVE.
                        if (lives_r != 2'd0) begin
                            lives_r <= lives_r - 2'd1;
                        end else begin
                            lives_r <= 2'd0;
                        end
                        if (lives_r <= 2'd1) begin
                            game_over_r <= 1'b1;
                        end else begin
                            game_over_r <= game_over_r;
                        end
                        reload_r <= 1'b1;
                    end else if (edge_col[1]) begin
                        if (edge_col[0]) begin
                            dir_r[1] <= ~dir_r[1];
                        end else begin
                            dir_r[0] <= ~dir_r[0];
                        end
                    end else if (brick_alive_s) begin
                        dir_r[1]    <= ~dir_r[1];
                        alive_r     <= alive_r & ~brick_mask_s;
                        clr_valid_r <= 1'b1;
                        clr_num_r   <= brick_num;
                    end else begin
                        dir_r <= dir_r;
                    end
                end
                ST_MOVE: begin
                    done_r <= 1'b1;
                    if (reload_r) begin
                        ball_x_r <= X_INIT_C;
                        ball_y_r <= Y_INIT_C;
                        dir_r    <= 2'b11;
                    end else begin
                        // dir was already updated in RESOLVE, so the candidate is the move.
                        ball_x_r <= cand_x_s;
                        ball_y_r <= cand_y_s;
                    end
                    if (alive_r == 12'd0) begin
                        win_r <= 1'b1;
                    end else begin
                        win_r <= win_r;
                    end
                end
                default: begin
                    reload_r <= reload_r;
                end
            endcase
        end
    end

    assign ball_x    = ball_x_r;
    assign ball_y    = ball_y_r;
    assign cand_x    = cand_x_s;
    assign cand_y    = cand_y_s;
    assign dir       = dir_r;
    assign alive     = alive_r;
    assign clr_valid = clr_valid_r;
    assign clr_num   = clr_num_r;
    assign lives     = lives_r;
    assign done      = done_r;
    assign win       = win_r;
    assign game_over = game_over_r;

endmodule
